grid_cursor_ctrl: RTL

Parametrised cursor-position controller for the VGA grid games. Takes four raw active-low push buttons, synchronises and debounces them, and steps a registered (row, col) cursor across a ROWS x COLS board. Supports selectable clamp or wrap-around at the edges and a direct position load, and reports each accepted or rejected move. Sits between the board button pins and the grid renderer/game FSM.

---
 rtl/grid_cursor_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/grid_cursor_ctrl.sv
// rtl/grid_cursor_ctrl.sv - debounced four-button (row, col) cursor controller with clamp/wrap and load
// Optional hold-to-repeat moves are built when AUTO_REPEAT_EN is defined.
module grid_cursor_ctrl #(
   parameter int ROWS            = 6,
   parameter int COLS            = 6,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_PERIOD   = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_btn_up_n,
   input  logic                      i_btn_down_n,
   input  logic                      i_btn_left_n,
   input  logic                      i_btn_right_n,
   input  logic                      i_wrap_en,
   input  logic                      i_load,
   input  logic [$clog2(ROWS)-1:0]   i_load_row,
   input  logic [$clog2(COLS)-1:0]   i_load_col,
   output logic [$clog2(ROWS)-1:0]   o_row,
   output logic [$clog2(COLS)-1:0]   o_col,
   output logic                      o_moved,
   output logic                      o_blocked
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   if (ROWS < 2 || COLS < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("grid_cursor_ctrl: illegal parameter value");
   end

   // Button index order doubles as move priority: 0 up, 1 down, 2 left, 3 right.
   logic [3:0]    w_btn_raw;
   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    r_db;
   logic [3:0]    r_db_d;
   logic [3:0]    r_press;
   logic [DW-1:0] r_db_cnt [4];
   logic [3:0]    w_event;

   assign w_btn_raw = {i_btn_right_n, i_btn_left_n, i_btn_down_n, i_btn_up_n};

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_db    <= '1;
         r_db_d  <= '1;
         r_press <= '0;
         for (int i = 0; i < 4; i++) begin
            r_db_cnt[i] <= '0;
         end
      end else begin
         r_db_d  <= r_db;
         r_press <= r_db_d & ~r_db;
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_db[i]     <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPW  = $clog2(RMAX + 1);

   logic [RPW-1:0] r_rep_cnt [4];
   logic [3:0]     r_rep_arm;
   logic [3:0]     w_rep;

   // Counter holds cycles left until the next repeat; a release disarms it at once.
   always_comb begin
      w_rep = '0;
      for (int i = 0; i < 4; i++) begin
         w_rep[i] = r_rep_arm[i] && !r_db[i] && (r_rep_cnt[i] == '0);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rep_arm <= '0;
         for (int i = 0; i < 4; i++) begin
            r_rep_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (r_db[i]) begin
               r_rep_arm[i] <= 1'b0;
               r_rep_cnt[i] <= '0;
            end else if (r_press[i]) begin
               r_rep_arm[i] <= 1'b1;
               r_rep_cnt[i] <= RPW'(REPEAT_DELAY - 1);
            end else if (w_rep[i]) begin
               r_rep_cnt[i] <= RPW'(REPEAT_PERIOD - 1);
            end else if (r_rep_arm[i]) begin
               r_rep_cnt[i] <= r_rep_cnt[i] - 1'b1;
            end
         end
      end
   end

   assign w_event = r_press | w_rep;
`else
   assign w_event = r_press;
`endif

   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic          r_moved;
   logic          r_blocked;
   logic [RW-1:0] w_row_nxt;
   logic [CW-1:0] w_col_nxt;
   logic [RW-1:0] w_load_row_sat;
   logic [CW-1:0] w_load_col_sat;
   logic          w_moved;
   logic          w_blocked;

   always_comb begin
      w_load_row_sat = (i_load_row > ROW_MAX) ? ROW_MAX : i_load_row;
      w_load_col_sat = (i_load_col > COL_MAX) ? COL_MAX : i_load_col;
      w_row_nxt      = r_row;
      w_col_nxt      = r_col;
      w_moved        = 1'b0;
      w_blocked      = 1'b0;
      if (i_load) begin
         w_row_nxt = w_load_row_sat;
         w_col_nxt = w_load_col_sat;
         w_moved   = (w_load_row_sat != r_row) || (w_load_col_sat != r_col);
      end else if (w_event[0]) begin
         if (r_row != '0) begin
            w_row_nxt = r_row - 1'b1;
            w_moved   = 1'b1;
         end else if (i_wrap_en) begin
            w_row_nxt = ROW_MAX;
            w_moved   = 1'b1;
         end else begin
            w_blocked = 1'b1;
         end
      end else if (w_event[1]) begin
         if (r_row != ROW_MAX) begin
            w_row_nxt = r_row + 1'b1;
            w_moved   = 1'b1;
         end else if (i_wrap_en) begin
            w_row_nxt = '0;
            w_moved   = 1'b1;
         end else begin
            w_blocked = 1'b1;
         end
      end else if (w_event[2]) begin
         if (r_col != '0) begin
            w_col_nxt = r_col - 1'b1;
            w_moved   = 1'b1;
         end else if (i_wrap_en) begin
            w_col_nxt = COL_MAX;
            w_moved   = 1'b1;
         end else begin
            w_blocked = 1'b1;
         end
      end else if (w_event[3]) begin
         if (r_col != COL_MAX) begin
            w_col_nxt = r_col + 1'b1;
            w_moved   = 1'b1;
         end else if (i_wrap_en) begin
            w_col_nxt = '0;
            w_moved   = 1'b1;
         end else begin
            w_blocked = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_row     <= '0;
         r_col     <= '0;
         r_moved   <= 1'b0;
         r_blocked <= 1'b0;
      end else begin
         r_row     <= w_row_nxt;
         r_col     <= w_col_nxt;
         r_moved   <= w_moved;
         r_blocked <= w_blocked;
      end
   end

   assign o_row     = r_row;
   assign o_col     = r_col;
   assign o_moved   = r_moved;
   assign o_blocked = r_blocked;

endmodule
